// File: rtl/kalman_pkg.sv
// Shared constants, FSM state type and triangular addressing for the Kalman datapath.
package kalman_pkg;

  localparam int unsigned DBL_WIDTH = 64;
  localparam int unsigned STATE_DIM = 12;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CAP    = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // Row-major upper-triangle index of (i,j), i <= j, in an n x n matrix.
  function automatic int unsigned tri_idx(input int unsigned i, input int unsigned j,
                                          input int unsigned n);
    return i * n + j - (i * (i + 1)) / 2;
  endfunction

endpackage

// File: rtl/p_pred_collector.sv
// Collects the upper triangle of the predicted covariance and streams the
// full symmetric matrix row-major over valid/ready.
module p_pred_collector
  import kalman_pkg::*;
(
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             start,
  input  logic [STATE_DIM*(STATE_DIM+1)/2-1:0]             elem_valid,
  input  logic [STATE_DIM*(STATE_DIM+1)/2*DBL_WIDTH-1:0]   elem_data,
  output logic                                             busy,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [DBL_WIDTH-1:0]                             out_data,
  output logic [$clog2(STATE_DIM)-1:0]                     out_row,
  output logic [$clog2(STATE_DIM)-1:0]                     out_col,
  output logic                                             out_last,
  output logic                                             done,
  output logic                                             err_dup,
  output logic                                             err_stray
);

  localparam int unsigned NUM_ELEM = STATE_DIM * (STATE_DIM + 1) / 2;
  localparam int unsigned RW       = $clog2(STATE_DIM);
  localparam int unsigned KW       = $clog2(NUM_ELEM);
  localparam logic [RW-1:0] LAST   = RW'(STATE_DIM - 1);

  state_e                 state_q, state_d;
  logic [NUM_ELEM-1:0]    mask_q;
  logic [DBL_WIDTH-1:0]   store_q [NUM_ELEM];

  logic                   cap_c, xfer_c, full_c, last_c;
  logic [RW-1:0]          row_d, col_d, lo_c, hi_c;
  logic [KW-1:0]          rd_idx_c;
  logic [DBL_WIDTH-1:0]   first_c;

  assign cap_c    = (state_q == S_CAP);
  assign xfer_c   = (state_q == S_STREAM) && out_valid && out_ready;
  assign full_c   = &(mask_q | elem_valid);
  assign last_c   = (out_row == LAST) && (out_col == LAST);
  assign lo_c     = (row_d < col_d) ? row_d : col_d;
  assign hi_c     = (row_d < col_d) ? col_d : row_d;
  assign rd_idx_c = KW'(tri_idx(32'(lo_c), 32'(hi_c), STATE_DIM));
  // Element (0,0) may land in the very cycle the mask completes.
  assign first_c  = (elem_valid[0] && !mask_q[0]) ? elem_data[DBL_WIDTH-1:0] : store_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    row_d   = out_row;
    col_d   = out_col;
    case (state_q)
      S_IDLE:   if (start) state_d = S_CAP;
      S_CAP:    if (full_c) state_d = S_STREAM;
      S_STREAM: begin
        if (xfer_c) begin
          if (last_c) begin
            state_d = S_DONE;
          end else if (out_col == LAST) begin
            col_d = '0;
            row_d = out_row + RW'(1);
          end else begin
            col_d = out_col + RW'(1);
          end
        end
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      err_dup   <= 1'b0;
      err_stray <= 1'b0;
      mask_q    <= '0;
      for (int k = 0; k < NUM_ELEM; k++) store_q[k] <= '0;
    end else begin
      busy      <= (state_d == S_CAP) || (state_d == S_STREAM);
      out_valid <= (state_d == S_STREAM);
      done      <= (state_d == S_DONE);

      if ((state_q == S_IDLE) && start) mask_q <= '0;

      // First pulse of an element wins; repeats only raise the sticky flag.
      if (cap_c) begin
        mask_q <= mask_q | elem_valid;
        for (int k = 0; k < NUM_ELEM; k++) begin
          if (elem_valid[k] && !mask_q[k])
            store_q[k] <= elem_data[k*DBL_WIDTH +: DBL_WIDTH];
        end
        if (|(mask_q & elem_valid)) err_dup <= 1'b1;
      end else if (|elem_valid) begin
        err_stray <= 1'b1;
      end

      if (cap_c && (state_d == S_STREAM)) begin
        out_row  <= '0;
        out_col  <= '0;
        out_data <= first_c;
        out_last <= 1'(STATE_DIM == 1);
      end else if (xfer_c && (state_d == S_STREAM)) begin
        out_row  <= row_d;
        out_col  <= col_d;
        out_data <= store_q[rd_idx_c];
        out_last <= (row_d == LAST) && (col_d == LAST);
      end else if (xfer_c) begin
        out_last <= 1'b0;
      end
    end
  end

endmodule
